uart_tx_x16: RTL
================

// Module: uart_tx_x16
// PURPOSE
//  UART transmitter: the transmit half of the FPGA UART transceiver, pairing with the x16-oversampled receiver.
//  Accepts one byte per valid/ready handshake and serialises it as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit).
//  Bit timing comes from an internal x16 baud tick divider, so both directions share one timing parameter.
//  The block sits between the user logic (byte source) and the FPGA TX pin.
// PARAMETERS
//  BAUD_X16_CLK_TICKS  651  clk cycles per x16 baud tick (clk / (16*baud)). Must be >= 2.
// PORTS
//  clk          in   1  system clock. Single clock domain.
//  reset        in   1  synchronous, active-high reset.
//  tx_data_in   in   8  byte to send. Sampled only on the accept cycle.
//  tx_valid     in   1  tx_data_in is valid.
//  tx_ready     out  1  block can accept a byte. High only in IDLE.
//  tx_data_out  out  1  serial line. Idle level is 1.
//  tx_busy      out  1  frame in progress (any state other than IDLE).
//  tx_done      out  1  one-clk pulse when a frame's stop bit completes.
// BEHAVIOUR
//  Reset:
//   - All outputs registered.
//   - On reset: tx_data_out=1, tx_ready=1, tx_busy=0, tx_done=0.
//   - State=IDLE, divider reloaded to BAUD_X16_CLK_TICKS-1, bit counters=0.
//   - Reset applied mid-frame aborts the frame: line is high the next clk, no tx_done, byte discarded.
//  Tick divider:
//   - Down-counter over $clog2(BAUD_X16_CLK_TICKS) bits.
//   - When count==0: pulse tick for 1 clk and reload to TICKS-1.
//   - Reloaded on accept, so every bit lasts exactly 16*TICKS clks.
//  Accept:
//   - A byte is accepted when tx_valid & tx_ready at a clk edge; this is not tick-gated.
//   - On accept: latch tx_data_in into the shift register and go to START.
//   - Next clk: tx_ready=0, tx_busy=1, tx_data_out=0.
//   - tx_valid while not ready is ignored; there is no queuing.
//   - tx_data_in changes after accept do not affect the frame.
//  FSM (IDLE, START, DATA, STOP); 4-bit tick counter tcnt and 3-bit bit index bidx:
//   - IDLE:  line=1. On accept -> START, tcnt=0.
//   - START: line=0. On each tick, tcnt++. On the tick where tcnt==15 -> DATA, tcnt=0, bidx=0.
//   - DATA:  line=shift[bidx] (LSB first). On the tick where tcnt==15:
//            if bidx==7 -> STOP, otherwise bidx++.
//   - STOP:  line=1. On the tick where tcnt==15 -> IDLE.
//            Next clk: tx_done=1 (one clk), tx_ready=1, tx_busy=0.
//   - Illegal state -> IDLE with line=1.
//  Timing:
//   - Accept to start-bit edge: 1 clk.
//   - Frame: 10*16*TICKS clks from start-bit edge to end of stop bit.
//   - Back-to-back: tx_valid held high gives a new accept on the tx_done cycle.
//     The next start bit follows 1 clk later, so the inter-frame gap is 1 clk of extra idle-high.
//   - tx_done and accept in the same cycle is legal.
//  Line output:
//   - tx_data_out is registered and glitch-free.
//   - It changes only on bit boundaries, on reset, or on the accept+1 edge.
// TESTING (sim with BAUD_X16_CLK_TICKS=4, so bit = 64 clks and frame = 640 clks)
//  1. Reset held for 5 clks, then released with tx_valid=0
//     -> tx_data_out=1, tx_ready=1, tx_busy=0, tx_done=0 for 1000 clks.
//  2. Send 0xA5 (one-cycle valid)
//     -> line 1 clk later = 0 for 64 clks; then data bits 1,0,1,0,0,1,0,1 at 64 clks each; then 1 for 64 clks.
//     -> tx_done pulses once at 641 clks after accept; a bench UART model decodes 0xA5.
//  3. Send 0x00 then 0xFF with tx_valid held high
//     -> second accept occurs on the tx_done cycle; both frames decode correctly; inter-frame gap is 1 clk.
//  4. Pulse tx_valid with 0x3C at 200 clks into a 0x81 frame
//     -> ignored; only 0x81 is transmitted; tx_ready stays 0 until tx_done.
//  5. Assert reset at clk 300 of a 0x55 frame
//     -> tx_data_out=1 next clk, no tx_done, tx_ready=1 after release; next byte 0x12 sends cleanly.
//  6. Loopback: tie tx_data_out to the receiver rx_data_in (same TICKS), send 0x00, 0x7E, 0xFF, 0x01
//     -> receiver output matches each byte in order.

Source files
------------

// File: rtl/uart_tx_x16.sv
// 8N1 UART transmitter with an internal x16 baud tick divider.
// One byte per valid/ready handshake; all outputs registered.
module uart_tx_x16 #(
  parameter int unsigned BAUD_X16_CLK_TICKS = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned DW = $clog2(BAUD_X16_CLK_TICKS);
  localparam logic [DW-1:0] RELOAD = DW'(BAUD_X16_CLK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] div;
  logic [DW-1:0] div_n;
  logic [3:0]    tcnt;
  logic [3:0]    tcnt_n;
  logic [2:0]    bidx;
  logic [2:0]    bidx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          line_n;
  logic          done_n;
  logic          tick;
  logic          accept;
  logic          last;

  assign tick   = (div == '0);
  assign accept = tx_valid & tx_ready;
  assign last   = tick & (tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div         <= RELOAD;
      tcnt        <= 4'd0;
      bidx        <= 3'd0;
      shift       <= 8'd0;
      tx_data_out <= 1'b1;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      state       <= state_n;
      div         <= div_n;
      tcnt        <= tcnt_n;
      bidx        <= bidx_n;
      shift       <= shift_n;
      tx_data_out <= line_n;
      tx_ready    <= (state_n == IDLE);
      tx_busy     <= (state_n != IDLE);
      tx_done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bidx_n  = bidx;
    shift_n = shift;
    done_n  = 1'b0;
    div_n   = tick ? RELOAD : div - 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          tcnt_n  = 4'd0;
          bidx_n  = 3'd0;
          shift_n = tx_data_in;
          div_n   = RELOAD;
        end
      end
      START: begin
        if (tick) tcnt_n = tcnt + 4'd1;
        if (last) begin
          state_n = DATA;
          bidx_n  = 3'd0;
        end
      end
      DATA: begin
        if (tick) tcnt_n = tcnt + 4'd1;
        if (last) begin
          if (bidx == 3'd7) state_n = STOP;
          else bidx_n = bidx + 3'd1;
        end
      end
      STOP: begin
        if (tick) tcnt_n = tcnt + 4'd1;
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tcnt_n  = 4'd0;
        bidx_n  = 3'd0;
      end
    endcase
  end

  // Line level follows the next state so it is registered with it.
  always_comb begin
    line_n = 1'b1;
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shift_n[bidx_n];
      default: line_n = 1'b1;
    endcase
  end

endmodule
